// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART front end: register offsets,
// IRQEN bit positions and a constant-foldable clog2 used to size FIFO pointers.
package mmio_uart_pkg;

    localparam logic [7:0] OFF_RXCTRL = 8'h00;
    localparam logic [7:0] OFF_TXCTRL = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_RXDATA = 8'h0C;
    localparam logic [7:0] OFF_LEVEL  = 8'h10;
    localparam logic [7:0] OFF_IRQEN  = 8'h14;
    localparam logic [7:0] OFF_CYCLE  = 8'h18;
    localparam logic [7:0] OFF_INSTR  = 8'h1C;

    localparam int IRQ_RX_BIT = 0;
    localparam int IRQ_TX_BIT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_uart_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is still accepted
// when a pop frees the slot on the same edge. Pop on empty is ignored.
module sync_fifo
    import mmio_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_fifo.sv
// MMIO UART front end: decodes the BASE_ADDR[31:8] window into RX/TX FIFOs,
// status, IRQ enables and edge IRQs. Optional counters: MMIO_CYCLE_COUNTER_EN.
module mmio_uart_fifo
    import mmio_uart_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [DATA_W-1:0] uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ready,
    output logic              rx_irq,
    output logic              tx_irq
);

    logic                      w_hit;
    logic                      w_access;
    logic                      w_write;
    logic [7:0]                w_off;
    logic                      w_tx_req;
    logic                      w_tx_pop;
    logic                      w_rx_push;
    logic                      w_rx_pop;
    logic                      w_txctrl_rd;
    logic                      w_irqen_wr;
    logic [DATA_W-1:0]         w_rx_dout;
    logic                      w_rx_full;
    logic                      w_rx_empty;
    logic [clog2(RX_DEPTH):0]  w_rx_count;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic [clog2(TX_DEPTH):0]  w_tx_count;
    logic [31:0]               w_level;
    logic                      w_unused;
    logic [1:0]                r_irq_en;
    logic                      r_overflow;
    logic                      r_prev_rx_nonempty;
    logic                      r_prev_tx_full;

    assign w_hit       = (addr[31:8] == BASE_ADDR[31:8]);
    assign w_off       = addr[7:0];
    assign w_write     = |we;
    assign w_access    = w_hit && !stall;
    assign w_tx_req    = w_access && w_write && (w_off == OFF_TXDATA);
    assign w_rx_pop    = w_access && re && (w_off == OFF_RXDATA) && !w_rx_empty;
    assign w_txctrl_rd = w_access && re && (w_off == OFF_TXCTRL);
    assign w_irqen_wr  = w_access && w_write && (w_off == OFF_IRQEN);
    assign w_unused    = ^wdata[31:DATA_W];

    // Both UART handshakes are blocked during reset so no byte is exchanged
    // in the cycle whose FIFO contents are being discarded.
    assign uart_tx_valid = !w_tx_empty && !rst;
    assign w_tx_pop      = uart_tx_valid && uart_tx_ready;
    // A CPU pop on a full RX FIFO frees the slot on the same edge, so ready may rise then.
    assign uart_rx_ready = (!w_rx_full || w_rx_pop) && !rst;
    assign w_rx_push     = uart_rx_valid && uart_rx_ready;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (uart_rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_req),
        .pop   (w_tx_pop),
        .din   (wdata[DATA_W-1:0]),
        .dout  (uart_tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en           <= 2'b00;
            r_overflow         <= 1'b0;
            r_prev_rx_nonempty <= 1'b0;
            r_prev_tx_full     <= 1'b0;
        end else begin
            r_prev_rx_nonempty <= !w_rx_empty;
            r_prev_tx_full     <= w_tx_full;
            if (w_irqen_wr) begin
                r_irq_en <= wdata[1:0];
            end
            // A push that lands on a full FIFO without a same-cycle drain is lost.
            if (w_tx_req && w_tx_full && !w_tx_pop) begin
                r_overflow <= 1'b1;
            end else if (w_txctrl_rd) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rx_irq = r_irq_en[IRQ_RX_BIT] && !w_rx_empty && !r_prev_rx_nonempty;
    assign tx_irq = r_irq_en[IRQ_TX_BIT] && !w_tx_full && r_prev_tx_full;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;
    logic        w_cnt_clear;

    assign w_cnt_clear = w_access && w_write &&
                         ((w_off == OFF_CYCLE) || (w_off == OFF_INSTR));

    always_ff @(posedge clk) begin
        if (rst || w_cnt_clear) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_access && (re || w_write)) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end
`endif

    assign w_level = ((32'(w_tx_count) & 32'h0000_00FF) << 16) |
                     (32'(w_rx_count) & 32'h0000_00FF);

    always_comb begin
        rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_RXCTRL: rdata = {31'd0, !w_rx_empty};
                OFF_TXCTRL: rdata = {30'd0, r_overflow, !w_tx_full};
                OFF_RXDATA: rdata = w_rx_empty ? 32'd0 : 32'(w_rx_dout);
                OFF_LEVEL:  rdata = w_level;
                OFF_IRQEN:  rdata = {30'd0, r_irq_en};
`ifdef MMIO_CYCLE_COUNTER_EN
                OFF_CYCLE:  rdata = r_cycle_cnt;
                OFF_INSTR:  rdata = r_instr_cnt;
`endif
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed self-checking bench for mmio_uart_fifo in its default build
// (DATA_W=8, depths 8); each scenario task drives and checks inline.
module tb_mmio_uart_fifo;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic        rx_irq;
    logic        tx_irq;

    int checks = 0;
    int passes = 0;

    mmio_uart_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .rx_irq        (rx_irq),
        .tx_irq        (tx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] off, input logic rd);
        addr = BASE | {24'd0, off};
        re   = rd;
        we   = 4'h0;
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] off, input logic [31:0] data);
        addr  = BASE | {24'd0, off};
        wdata = data;
        we    = 4'hF;
        re    = 1'b0;
        step();
        we    = 4'h0;
    endtask

    task automatic uart_push(input logic [7:0] data);
        uart_rx_data  = data;
        uart_rx_valid = 1'b1;
        step();
        uart_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] expv [6];
        expv = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_addr(8'(i * 4), 1'b0);
            checks++;
            if (rdata !== expv[i])
                $display("[TB] FAIL reset_reg_%0h: got %h want %h", i * 4, rdata, expv[i]);
            else passes++;
        end
        checks++;
        if (uart_rx_ready !== 1'b1) $display("[TB] FAIL reset_rx_ready: got %b want 1", uart_rx_ready);
        else passes++;
        checks++;
        if (uart_tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid: got %b want 0", uart_tx_valid);
        else passes++;
        addr = 32'h9000_0004;
        #1;
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL window_miss: got %h want 0", rdata);
        else passes++;
        set_addr(8'h20, 1'b0);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL unmapped_off: got %h want 0", rdata);
        else passes++;
    endtask

    task automatic test_tx_order();
        logic [7:0] bytes [3];
        bytes = '{8'h41, 8'h42, 8'h43};
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(8'h08, {24'd0, bytes[i]});
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'h0003_0000) $display("[TB] FAIL tx_level3: got %h want 00030000", rdata);
        else passes++;
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (uart_tx_valid !== 1'b1 || uart_tx_data !== bytes[i])
                $display("[TB] FAIL tx_order_%0d: got v=%b d=%h want v=1 d=%h",
                         i, uart_tx_valid, uart_tx_data, bytes[i]);
            else passes++;
            step();
        end
        checks++;
        if (uart_tx_valid !== 1'b0) $display("[TB] FAIL tx_drained: got %b want 0", uart_tx_valid);
        else passes++;
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_rx_irq();
        cpu_write(8'h14, 32'd1);
        set_addr(8'h14, 1'b0);
        checks++;
        if (rdata !== 32'd1) $display("[TB] FAIL irqen_rb: got %h want 1", rdata);
        else passes++;
        uart_rx_data  = 8'h5A;
        uart_rx_valid = 1'b1;
        #1;
        checks++;
        if (rx_irq !== 1'b0) $display("[TB] FAIL rx_irq_early: got %b want 0", rx_irq);
        else passes++;
        step();
        uart_rx_valid = 1'b0;
        checks++;
        if (rx_irq !== 1'b1) $display("[TB] FAIL rx_irq_pulse: got %b want 1", rx_irq);
        else passes++;
        step();
        checks++;
        if (rx_irq !== 1'b0) $display("[TB] FAIL rx_irq_once: got %b want 0", rx_irq);
        else passes++;
        set_addr(8'h00, 1'b0);
        checks++;
        if (rdata !== 32'd1) $display("[TB] FAIL rxctrl_full: got %h want 1", rdata);
        else passes++;
        set_addr(8'h0C, 1'b1);
        checks++;
        if (rdata !== 32'h0000_005A) $display("[TB] FAIL rxdata: got %h want 0000005a", rdata);
        else passes++;
        step();
        set_addr(8'h00, 1'b0);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL rxctrl_empty: got %h want 0", rdata);
        else passes++;
        set_addr(8'h0C, 1'b1);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL rxdata_empty: got %h want 0", rdata);
        else passes++;
        step();
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL empty_pop_level: got %h want 0", rdata);
        else passes++;
    endtask

    task automatic test_tx_overflow();
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) cpu_write(8'h08, 32'h10 + i);
        cpu_write(8'h08, 32'h99);
        set_addr(8'h04, 1'b0);
        checks++;
        if (rdata !== 32'd2) $display("[TB] FAIL txctrl_ovf: got %h want 2", rdata);
        else passes++;
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'h0008_0000) $display("[TB] FAIL tx_level8: got %h want 00080000", rdata);
        else passes++;
        set_addr(8'h04, 1'b1);
        step();
        set_addr(8'h04, 1'b0);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL txctrl_clear: got %h want 0", rdata);
        else passes++;
        cpu_write(8'h14, 32'd2);
        uart_tx_ready = 1'b1;
        #1;
        checks++;
        if (tx_irq !== 1'b0) $display("[TB] FAIL tx_irq_early: got %b want 0", tx_irq);
        else passes++;
        step();
        uart_tx_ready = 1'b0;
        #1;
        checks++;
        if (tx_irq !== 1'b1) $display("[TB] FAIL tx_irq_pulse: got %b want 1", tx_irq);
        else passes++;
        step();
        checks++;
        if (tx_irq !== 1'b0) $display("[TB] FAIL tx_irq_once: got %b want 0", tx_irq);
        else passes++;
        uart_tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1;
            checks++;
            if (uart_tx_data !== 8'(8'h10 + i))
                $display("[TB] FAIL tx_drain_%0d: got %h want %h", i, uart_tx_data, 8'(8'h10 + i));
            else passes++;
            step();
        end
        checks++;
        if (uart_tx_valid !== 1'b0) $display("[TB] FAIL tx_ovf_dropped: got %b want 0", uart_tx_valid);
        else passes++;
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_stall();
        uart_push(8'hA1);
        uart_push(8'hA2);
        stall = 1'b1;
        set_addr(8'h0C, 1'b1);
        step();
        checks++;
        if (rdata !== 32'h0000_00A1) $display("[TB] FAIL stall_head: got %h want 000000a1", rdata);
        else passes++;
        cpu_write(8'h08, 32'h55);
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'h0000_0002) $display("[TB] FAIL stall_level: got %h want 00000002", rdata);
        else passes++;
        stall = 1'b0;
        set_addr(8'h0C, 1'b1);
        step();
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'h0000_0001) $display("[TB] FAIL unstall_pop: got %h want 00000001", rdata);
        else passes++;
        set_addr(8'h0C, 1'b1);
        checks++;
        if (rdata !== 32'h0000_00A2) $display("[TB] FAIL unstall_next: got %h want 000000a2", rdata);
        else passes++;
        step();
        re = 1'b0;
    endtask

    task automatic test_full_simul();
        logic [7:0] expb;
        for (int i = 0; i < 8; i++) uart_push(8'(8'h60 + i));
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'h0000_0008 || uart_rx_ready !== 1'b0)
            $display("[TB] FAIL rx_full: got level=%h rdy=%b want 00000008 rdy=0", rdata, uart_rx_ready);
        else passes++;
        uart_rx_data  = 8'h77;
        uart_rx_valid = 1'b1;
        set_addr(8'h0C, 1'b1);
        checks++;
        if (uart_rx_ready !== 1'b1 || rdata !== 32'h60)
            $display("[TB] FAIL simul_ready: got rdy=%b d=%h want rdy=1 d=60", uart_rx_ready, rdata);
        else passes++;
        step();
        uart_rx_valid = 1'b0;
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'h0000_0008) $display("[TB] FAIL simul_level: got %h want 00000008", rdata);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            expb = (i == 7) ? 8'h77 : 8'(8'h61 + i);
            set_addr(8'h0C, 1'b1);
            checks++;
            if (rdata !== {24'd0, expb})
                $display("[TB] FAIL simul_read_%0d: got %h want %h", i, rdata, {24'd0, expb});
            else passes++;
            step();
        end
        re = 1'b0;
        uart_push(8'hC1);
        uart_push(8'hC2);
        cpu_write(8'h08, 32'h33);
        rst           = 1'b1;
        uart_rx_data  = 8'hEE;
        uart_rx_valid = 1'b1;
        step();
        rst           = 1'b0;
        uart_rx_valid = 1'b0;
        set_addr(8'h10, 1'b0);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL midrst_level: got %h want 0", rdata);
        else passes++;
        checks++;
        if (uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1)
            $display("[TB] FAIL midrst_hs: got txv=%b rxr=%b want 0 1", uart_tx_valid, uart_rx_ready);
        else passes++;
        set_addr(8'h14, 1'b0);
        checks++;
        if (rdata !== 32'd0) $display("[TB] FAIL midrst_irqen: got %h want 0", rdata);
        else passes++;
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        addr          = 32'd0;
        wdata         = 32'd0;
        we            = 4'h0;
        re            = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'd0;
        uart_rx_valid = 1'b0;
        test_reset();
        test_tx_order();
        test_rx_irq();
        test_tx_overflow();
        test_stall();
        test_full_simul();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_fifo.md
Name: mmio_uart_fifo

Overview:
- Memory-mapped UART front end for the 3-stage CPU. Supersedes the unbuffered one-byte UART decode.
- Places parametrised RX and TX FIFOs between the CPU data port (X/Y stage address and data, stall-aware) and the byte-wide ready/valid UART core.
- Provides level status, FIFO occupancy and one-cycle edge interrupt requests for the COP0 interrupt inputs.
- Decodes only the 0x8000_00xx window and ignores all other addresses.

Parameters:
- DATA_W, 8: UART character width, 5..8.
- RX_DEPTH, 8: RX FIFO entries, power of two, 2..256.
- TX_DEPTH, 8: TX FIFO entries, power of two, 2..256.
- BASE_ADDR, 32'h8000_0000: base of the register window; bits [31:8] must match.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset; synchronous and active-high.
- stall, in, 1: CPU pipeline stall; when high, no MMIO side effects occur.
- addr, in, 32: data address from the execute stage.
- wdata, in, 32: store data; low DATA_W bits are used.
- we, in, 4: byte write enables; any bit set counts as a write.
- re, in, 1: load in progress (MemToReg).
- rdata, out, 32: combinational read data for the current addr.
- uart_tx_data, out, DATA_W: byte to the UART core.
- uart_tx_valid, out, 1: TX FIFO not empty.
- uart_tx_ready, in, 1: UART core accepts a byte.
- uart_rx_data, in, DATA_W: received byte.
- uart_rx_valid, in, 1: received byte available.
- uart_rx_ready, out, 1: RX FIFO not full.
- rx_irq, out, 1: one-cycle pulse when the RX FIFO goes empty to non-empty, gated by irq_en[0].
- tx_irq, out, 1: one-cycle pulse when the TX FIFO goes full to not-full, gated by irq_en[1].

Behaviour:
- Register map as offsets from BASE_ADDR; only addr[7:0] is decoded after the [31:8] match.
  - 0x00 RXCTRL (read-only): bit0 = RX not empty.
  - 0x04 TXCTRL (read-only): bit0 = TX not full.
  - 0x08 TXDATA (write-only): pushes wdata[DATA_W-1:0].
  - 0x0C RXDATA (read): zero-extended head entry; pops it.
  - 0x10 LEVEL (read-only): [23:16] = TX count, [7:0] = RX count.
  - 0x14 IRQEN (read/write): bits [1:0].
  - 0x18 and 0x1C: see Optional Feature.
  - Unmapped offset or no window match: rdata = 0, no side effect.
- A side effect occurs only on a rising clk edge with stall=0 and a window hit.
  - rdata is purely combinational and does not depend on stall.
- RXDATA read (re=1) when empty: returns 0, no pop, no pointer change.
- TXDATA write when full: byte dropped; sticky overflow flag is set, readable at TXCTRL bit1, cleared by reading TXCTRL.
- UART side pushes and pops follow standard ready/valid: a transfer happens on a cycle where both are high.
- Simultaneous push and pop on the same FIFO in one cycle:
  - Both take effect; count is unchanged.
  - If the FIFO is full, the pop frees the slot and the push is accepted.
  - A pop on an empty FIFO never happens.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Read latency: RXDATA is valid in the same cycle as addr. The CPU registers it into Z.
- Irq edges are detected from registered previous-state flags (prev_rx_nonempty, prev_tx_full). The pulse is asserted in the cycle after the transition.
- Reset values:
  - Both FIFOs empty, pointers 0.
  - irq_en = 2'b00, overflow = 0.
  - rx_irq = tx_irq = 0.
  - uart_tx_valid = 0, uart_rx_ready = 1.
  - Prev-state flags cleared, cycle counter = 0.
- Reset mid-operation discards all FIFO contents with no UART transfer in that cycle. A byte offered on uart_rx_* during the reset cycle is not captured.

Optional Feature:
- Macro: MMIO_CYCLE_COUNTER_EN.
- Defined:
  - 0x18 reads a free-running 32-bit cycle counter; it increments every cycle, including stall cycles, and wraps at 2^32.
  - 0x1C reads a 32-bit count of retired MMIO accesses: window hits with stall=0.
  - Any write to 0x18 or 0x1C clears both counters on that edge. A clear has priority over the increment in the same cycle.
- Undefined: 0x18 and 0x1C read 0, writes are ignored, and no counter flops are present.

Decomposition:
- Package mmio_uart_pkg:
  - Offset constants: OFF_RXCTRL, OFF_TXCTRL, OFF_TXDATA, OFF_RXDATA, OFF_LEVEL, OFF_IRQEN, OFF_CYCLE, OFF_INSTR.
  - IRQEN bit index constants.
  - clog2 helper.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).
  - Instantiated twice, once for RX and once for TX.

Test Plan:
- Reset, then read all 0x00..0x14 → rdata 0, 1, 0, 0, 0, 0; uart_rx_ready = 1; uart_tx_valid = 0.
- Write 0x41, 0x42, 0x43 to TXDATA with uart_tx_ready = 0 → LEVEL = 0x0003_0000. Then hold ready high → bytes 41, 42, 43 emitted in order, one per cycle, then uart_tx_valid = 0.
- Write IRQEN = 1, then drive uart_rx_data = 0x5A for one cycle → rx_irq pulses exactly once, one cycle later. RXCTRL = 1; RXDATA read returns 0x0000_005A; RXCTRL then reads 0.
- Fill TX to TX_DEPTH = 8, write a ninth byte (0x99) → 0x99 is dropped, TXCTRL = 0b10. Read TXCTRL → TXCTRL = 0b00. With IRQEN = 2, drain one byte → tx_irq pulses once.
- RXDATA read with stall = 1 on a non-empty FIFO → rdata shows the head but count is unchanged. Deassert stall → pop occurs on that edge.
- RX full (count 8) with a same-cycle CPU pop and UART push of 0x77 → count stays 8; 0x77 is the last entry read out. Assert rst mid-stream → LEVEL = 0 on the next cycle.
